// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: turns jump, load-use hazard and debug halt events into
// PC select/stall/flush controls. Define FETCH_SEQ_PERF_EN to add stall/flush/jump counters.
module fetch_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned BOOT_CYCLES  = 1,
   parameter int unsigned ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              hazard_req,
   input  logic              halt_req,
   input  logic              resume,
   output logic              pc_mux_sel,
   output logic [ADDR_W-1:0] jmp_loc,
   output logic              stall,
   output logic              stall_pm,
   output logic              flush,
   output logic              halted,
   output logic [2:0]        fsm_state
`ifdef FETCH_SEQ_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
   output logic [31:0]       jump_cnt
`endif
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned PERF_W = 32;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STALL = 3'd2,
      ST_JUMP  = 3'd3,
      ST_FLUSH = 3'd4,
      ST_HALT  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   jmp_loc_q, jmp_loc_d;
   logic                pc_mux_sel_q, pc_mux_sel_d;
   logic                flush_q, flush_d;
   logic                stall_q, stall_d;
   logic                stall_pm_q, stall_pm_d;
   logic                halted_q, halted_d;

   // State, counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_BOOT;
         cnt_q        <= CNT_W'(BOOT_CYCLES);
         jmp_loc_q    <= '0;
         pc_mux_sel_q <= 1'b0;
         flush_q      <= 1'b0;
         stall_q      <= 1'b0;
         stall_pm_q   <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         jmp_loc_q    <= jmp_loc_d;
         pc_mux_sel_q <= pc_mux_sel_d;
         flush_q      <= flush_d;
         stall_q      <= stall_d;
         stall_pm_q   <= stall_pm_d;
         halted_q     <= halted_d;
      end
   end

   // Next state; outputs are decoded from the state being entered so they are Moore and registered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      jmp_loc_d = jmp_loc_q;

      case (state_q)
         ST_BOOT: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (jump_req) begin
               state_d   = ST_JUMP;
               jmp_loc_d = jump_target;
            end else if (hazard_req) begin
               state_d = ST_STALL;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end
         end
         ST_JUMP: begin
            // The JUMP cycle itself is the first flush cycle
            if (FLUSH_CYCLES > 1) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (jump_req) begin
               state_d   = ST_JUMP;
               jmp_loc_d = jump_target;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_STALL: begin
            if (jump_req) begin
               state_d   = ST_JUMP;
               jmp_loc_d = jump_target;
            end else if (!hazard_req) begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
            cnt_d   = CNT_W'(BOOT_CYCLES);
         end
      endcase

      pc_mux_sel_d = (state_d == ST_JUMP);
      flush_d      = (state_d == ST_BOOT) || (state_d == ST_JUMP) || (state_d == ST_FLUSH);
      stall_d      = (state_d == ST_STALL) || (state_d == ST_HALT);
      halted_d     = (state_d == ST_HALT);
      // Instruction hold trails the PC hold by the memory read latency
      stall_pm_d   = stall_q;
   end

   assign pc_mux_sel = pc_mux_sel_q;
   assign jmp_loc    = jmp_loc_q;
   assign stall      = stall_q;
   assign stall_pm   = stall_pm_q;
   assign flush      = flush_q;
   assign halted     = halted_q;
   assign fsm_state  = state_q;

`ifdef FETCH_SEQ_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [PERF_W-1:0] jump_cnt_q, jump_cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         jump_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         jump_cnt_q  <= jump_cnt_d;
      end
   end

   // Saturating event counters; JUMP lasts one cycle so each pc_mux_sel cycle is one entry
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      jump_cnt_d  = jump_cnt_q;
      if (stall_q && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if (flush_q && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
      if (pc_mux_sel_q && (jump_cnt_q != '1)) jump_cnt_d = jump_cnt_q + PERF_W'(1);
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign jump_cnt  = jump_cnt_q;
`else
   // Build without performance counters
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Central controller for the instruction-fetch stage.
- Turns pipeline events into the fetch-stage control signals: jump requests from execute, load-use hazards from decode, and halt/resume from debug.
- Drives the stage's PC select, jump target, PC stall and instruction-hold lines, plus a flush line that turns the decode slot into a NOP.
- Sits between the hazard/branch logic and the program-memory fetch block.

Parameters:
- FLUSH_CYCLES, 2: number of cycles flush stays high after a jump. Covers the 1-cycle registered program-memory latency plus the in-flight slot. Legal range 1..7.
- BOOT_CYCLES, 1: number of cycles flush stays high after reset release, while memory output is not yet valid. Legal range 1..7.
- ADDR_W, 16: width of the jump target.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- jump_req  in  1  execute has resolved a taken jump or branch; single-cycle pulse.
- jump_target  in  ADDR_W  jump destination; sampled when jump_req=1.
- hazard_req  in  1  decode requests a stall, held high for as long as needed.
- halt_req  in  1  debug halt request; level.
- resume  in  1  debug resume; pulse.
- pc_mux_sel  out  1  selects jmp_loc as the next PC.
- jmp_loc  out  ADDR_W  registered jump target.
- stall  out  1  holds the PC.
- stall_pm  out  1  holds the previous instruction. Equals stall delayed by one cycle.
- flush  out  1  decode must treat the current instruction as a NOP.
- halted  out  1  high while in HALT.
- fsm_state  out  3  current state encoding, for debug.

Behaviour:
- All outputs are registered (Moore). Each output reflects the state entered at the preceding rising edge. Response latency to any request is 1 cycle.
- Reset values: every output 0; jmp_loc=0; state=BOOT; flush/boot counter loaded with BOOT_CYCLES.
- State encodings: BOOT=0, RUN=1, STALL=2, JUMP=3, FLUSH=4, HALT=5.
- BOOT:
  - flush=1.
  - Counter decrements each cycle; when it reaches 0, go to RUN.
  - Requests arriving during BOOT are ignored, except reset.
- RUN:
  - All control outputs are 0.
  - Request priority per cycle: jump_req > hazard_req > halt_req.
  - jump_req → JUMP, latching jump_target into jmp_loc.
  - hazard_req → STALL.
  - halt_req → HALT.
- JUMP (exactly 1 cycle):
  - pc_mux_sel=1, jmp_loc valid, flush=1.
  - Next state is FLUSH with counter = FLUSH_CYCLES-1.
  - If FLUSH_CYCLES=1, next state is RUN.
- FLUSH:
  - flush=1, pc_mux_sel=0.
  - Counter decrements; at 0, go to RUN.
  - A new jump_req during FLUSH restarts at JUMP with the new target.
  - hazard_req or halt_req during FLUSH is deferred until RUN. The requester holds the level.
- STALL:
  - stall=1.
  - Stay while hazard_req=1; return to RUN the cycle after hazard_req drops.
  - jump_req during STALL preempts: go to JUMP and drop stall.
- HALT:
  - stall=1, halted=1.
  - A resume pulse → RUN.
  - jump_req and hazard_req are ignored; upstream is frozen while halted.
  - If resume and halt_req are both high in the same cycle, resume wins for that cycle. Re-entry to HALT then happens from RUN if halt_req is still high.
- stall_pm:
  - Register copy of stall, so the instruction hold lines up with the memory read latency.
  - Remains 1 for one cycle after stall falls.
- Reset mid-operation: asynchronous return to BOOT from any state. Any pending jmp_loc and counters are discarded.
- Counters are 3-bit down-counters and never wrap below 0.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined, adds three output ports:
  - stall_cnt[31:0]: cycles with stall=1.
  - flush_cnt[31:0]: cycles with flush=1.
  - jump_cnt[31:0]: JUMP entries.
- All three counters saturate at 0xFFFFFFFF and are cleared by reset.
- When the macro is not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with BOOT_CYCLES=1 → flush=1 for exactly 1 cycle, then RUN (fsm_state=1) with all controls 0.
- Pulse jump_req with jump_target=16'h0040 while in RUN → next cycle: pc_mux_sel=1, jmp_loc=0x0040, flush=1. Then flush=1 for 1 more cycle (FLUSH_CYCLES=2), then RUN.
- Hold hazard_req for 3 cycles → stall=1 for 3 cycles starting 1 cycle later; stall_pm=1 for 3 cycles, lagging stall by 1.
- Raise hazard_req, then pulse jump_req (target 0x0100) in the second stall cycle → stall drops, JUMP with jmp_loc=0x0100, then FLUSH, then RUN. Because hazard_req is still held, the controller then re-enters STALL.
- Raise halt_req, then pulse jump_req and then resume → halted=1 and stall=1 until resume; the jump is ignored and jmp_loc is unchanged; halted=0 one cycle after resume.
- Assert reset asynchronously mid-FLUSH → all outputs 0 immediately, state BOOT. With FETCH_SEQ_PERF_EN defined, all counters read 0.
